// File: rtl/poly_eval_arbiter_pkg.sv
// Shared types for the two-requester quadratic evaluator: FSM states, ALU ops,
// operand selects and the per-state micro-program decode.
package poly_eval_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MUL_BX = 3'd1,
    ST_ADD_C  = 3'd2,
    ST_MUL_XX = 3'd3,
    ST_MUL_A  = 3'd4,
    ST_ADD_R  = 3'd5,
    ST_DONE   = 3'd6
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  typedef enum logic [2:0] {
    SEL_A = 3'd0,
    SEL_B = 3'd1,
    SEL_C = 3'd2,
    SEL_X = 3'd3,
    SEL_T = 3'd4,
    SEL_U = 3'd5
  } sel_e;

  typedef struct packed {
    sel_e sel_l;
    sel_e sel_r;
    logic op;
    logic t_we;
    logic u_we;
  } alu_ctrl_t;

  // t accumulates b*x + c, u accumulates a*x*x; ADD_R sums them into the result.
  function automatic alu_ctrl_t step_ctrl(input state_e s);
    alu_ctrl_t c;
    c       = '0;
    c.sel_l = SEL_A;
    c.sel_r = SEL_A;
    c.op    = OP_ADD;
    case (s)
      ST_MUL_BX: begin c.sel_l = SEL_B; c.sel_r = SEL_X; c.op = OP_MUL; c.t_we = 1'b1; end
      ST_ADD_C:  begin c.sel_l = SEL_T; c.sel_r = SEL_C; c.op = OP_ADD; c.t_we = 1'b1; end
      ST_MUL_XX: begin c.sel_l = SEL_X; c.sel_r = SEL_X; c.op = OP_MUL; c.u_we = 1'b1; end
      ST_MUL_A:  begin c.sel_l = SEL_U; c.sel_r = SEL_A; c.op = OP_MUL; c.u_we = 1'b1; end
      ST_ADD_R:  begin c.sel_l = SEL_U; c.sel_r = SEL_T; c.op = OP_ADD; end
      default:   ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/poly_eval_arbiter_alu_dp.sv
// Operand/temp register file with two select muxes feeding one W-bit add/mul ALU.
module poly_alu_dp
  import poly_eval_arbiter_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  input  logic [W-1:0] x_i,
  input  alu_ctrl_t    ctrl_i,
  output logic [W-1:0] y_o
);

  logic [W-1:0] a_q, b_q, c_q, x_q, t_q, u_q;
  logic [W-1:0] l_opnd, r_opnd;

  function automatic logic [W-1:0] pick(input sel_e s);
    case (s)
      SEL_A:   return a_q;
      SEL_B:   return b_q;
      SEL_C:   return c_q;
      SEL_X:   return x_q;
      SEL_T:   return t_q;
      SEL_U:   return u_q;
      default: return '0;
    endcase
  endfunction

  always_comb begin
    l_opnd = pick(ctrl_i.sel_l);
    r_opnd = pick(ctrl_i.sel_r);
  end

  // Products and sums wrap to W bits at every step.
  always_comb begin
    y_o = '0;
    if (ctrl_i.op == OP_MUL) y_o = l_opnd * r_opnd;
    else                     y_o = l_opnd + r_opnd;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      x_q <= '0;
      t_q <= '0;
      u_q <= '0;
    end else begin
      if (load_i) begin
        a_q <= a_i;
        b_q <= b_i;
        c_q <= c_i;
        x_q <= x_i;
      end
      if (ctrl_i.t_we) t_q <= y_o;
      if (ctrl_i.u_we) u_q <= y_o;
    end
  end

endmodule

// File: rtl/poly_eval_arbiter.sv
// Round-robin arbiter and micro-program sequencer for y = A*x^2 + B*x + C mod 2^W,
// shared by two valid/ready requesters with an ID-tagged valid/ready response.
module poly_eval_arbiter
  import poly_eval_arbiter_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [W-1:0] req0_c,
  input  logic [W-1:0] req0_x,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [W-1:0] req1_c,
  input  logic [W-1:0] req1_x,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [W-1:0] resp_data,
  output logic         resp_id,
  output logic         busy
);

  state_e       state_q;
  logic         ptr_q;
  logic         id_q;
  logic         resp_valid_q;
  logic [W-1:0] resp_data_q;
  logic         resp_id_q;
  logic         busy_q;

  logic         idle;
  logic         grant0, grant1, accept;
  logic [W-1:0] sel_a, sel_b, sel_c, sel_x;
  logic [W-1:0] alu_y;
  alu_ctrl_t    ctrl;

  // ptr_q = 0 prefers requester 0 when both are valid.
  assign idle       = (state_q == ST_IDLE);
  assign grant0     = req0_valid & (~req1_valid | ~ptr_q);
  assign grant1     = req1_valid & (~req0_valid |  ptr_q);
  assign req0_ready = idle & grant0;
  assign req1_ready = idle & grant1;
  assign accept     = req0_ready | req1_ready;

  assign sel_a = req1_ready ? req1_a : req0_a;
  assign sel_b = req1_ready ? req1_b : req0_b;
  assign sel_c = req1_ready ? req1_c : req0_c;
  assign sel_x = req1_ready ? req1_x : req0_x;

  assign ctrl = step_ctrl(state_q);

  poly_alu_dp #(.W(W)) u_dp (
    .clk    (clk),
    .resetn (resetn),
    .load_i (accept),
    .a_i    (sel_a),
    .b_i    (sel_b),
    .c_i    (sel_c),
    .x_i    (sel_x),
    .ctrl_i (ctrl),
    .y_o    (alu_y)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      ptr_q        <= 1'b0;
      id_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            id_q    <= req1_ready;
            ptr_q   <= ~req1_ready;
            busy_q  <= 1'b1;
            state_q <= ST_MUL_BX;
          end
        end
        ST_MUL_BX: state_q <= ST_ADD_C;
        ST_ADD_C:  state_q <= ST_MUL_XX;
        ST_MUL_XX: state_q <= ST_MUL_A;
        ST_MUL_A:  state_q <= ST_ADD_R;
        ST_ADD_R: begin
          resp_data_q  <= alu_y;
          resp_id_q    <= id_q;
          resp_valid_q <= 1'b1;
          state_q      <= ST_DONE;
        end
        ST_DONE: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          resp_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_poly_eval_arbiter.sv
// Directed bench for poly_eval_arbiter: a transaction-level model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_poly_eval_arbiter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req0_c = '0, req0_x = '0;
  logic [W-1:0] req1_a = '0, req1_b = '0, req1_c = '0, req1_x = '0;
  logic         resp_valid, resp_ready = 1'b0;
  logic [W-1:0] resp_data;
  logic         resp_id, busy;

  always #5 clk = ~clk;

  poly_eval_arbiter #(.W(W)) dut (
    .clk(clk), .resetn(resetn),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_c(req0_c), .req0_x(req0_x),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_c(req1_c), .req1_x(req1_x),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id), .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_dut_resp = 0;
  bit chk_en  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (resetn && resp_valid && resp_ready) n_dut_resp++;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction model: accept -> result visible 5 edges later -> held until taken.
  bit         m_busy = 0, m_valid = 0, m_ptr = 0, m_id = 0, p_id = 0;
  bit         mg0, mg1;
  int         m_cnt = 0;
  logic [7:0] m_data = '0, p_data = '0;

  function automatic logic [7:0] poly(input int a, input int b, input int c, input int x);
    return 8'((a * x * x + b * x + c) & 255);
  endfunction

  always @(posedge clk) begin
    if (!resetn) begin
      m_busy = 0; m_valid = 0; m_ptr = 0; m_cnt = 0; m_data = '0; m_id = 0;
    end else if (!m_busy) begin
      mg0 = req0_valid && (!req1_valid || !m_ptr);
      mg1 = req1_valid && !mg0;
      if (mg0 || mg1) begin
        p_id   = mg1;
        p_data = mg1 ? poly(req1_a, req1_b, req1_c, req1_x) : poly(req0_a, req0_b, req0_c, req0_x);
        m_ptr  = !mg1;
        m_busy = 1;
        m_cnt  = 0;
      end
    end else if (!m_valid) begin
      m_cnt++;
      if (m_cnt == 5) begin
        m_valid = 1; m_data = p_data; m_id = p_id;
      end
    end else if (resp_ready) begin
      m_valid = 0;
      m_busy  = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, m_busy);
      chk("resp_valid", resp_valid, m_valid);
      chk("req0_ready", req0_ready, !m_busy && req0_valid && (!req1_valid || !m_ptr));
      chk("req1_ready", req1_ready, !m_busy && req1_valid && (!req0_valid || m_ptr));
      chk("ready_exclusive", req0_ready & req1_ready, 0);
      if (m_valid) begin
        chk("resp_data", resp_data, m_data);
        chk("resp_id", resp_id, m_id);
      end
    end
  end

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic send(input bit p, input int a, input int b, input int c, input int x,
                      output int acc_cyc);
    bit ok;
    if (p) begin
      req1_a = W'(a); req1_b = W'(b); req1_c = W'(c); req1_x = W'(x); req1_valid = 1'b1;
    end else begin
      req0_a = W'(a); req0_b = W'(b); req0_c = W'(c); req0_x = W'(x); req0_valid = 1'b1;
    end
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (p ? req1_ready : req0_ready) begin ok = 1; break; end
    end
    chk("accept_timeout", ok, 1);
    sync();
    acc_cyc = cyc;
    if (p) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic get_resp(input int acc_cyc, output int d, output int id, output int lat);
    bit ok;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (resp_valid) begin ok = 1; break; end
    end
    chk("resp_timeout", ok, 1);
    d   = resp_data;
    id  = resp_id;
    lat = cyc - acc_cyc;
    sync();
  endtask

  task automatic pulse_reset();
    resetn = 1'b0;
    sync();
    resetn = 1'b1;
  endtask

  int acc, d, id, lat, base, g;
  int exp_order [4] = '{0, 1, 0, 1};

  initial begin
    resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    chk_en = 1'b1;

    @(negedge clk);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_id", resp_id, 0);
    sync();

    // Basic
    send(0, 2, 3, 4, 5, acc);
    @(negedge clk);
    chk("basic_busy_after_accept", busy, 1);
    get_resp(acc, d, id, lat);
    chk("basic_data", d, 69);
    chk("basic_id", id, 0);
    chk("basic_latency", lat, 5);
    @(negedge clk);
    chk("basic_busy_after_resp", busy, 0);
    sync();

    // Wrap
    send(1, 1, 0, 0, 16, acc);
    get_resp(acc, d, id, lat);
    chk("wrap1_data", d, 0);
    chk("wrap1_id", id, 1);
    send(1, 16, 1, 0, 4, acc);
    get_resp(acc, d, id, lat);
    chk("wrap2_data", d, 4);
    chk("wrap2_id", id, 1);

    // Contention from reset, two rounds
    pulse_reset();
    req0_a = 8'd2; req0_b = 8'd3; req0_c = 8'd4; req0_x = 8'd5;
    req1_a = 8'd1; req1_b = 8'd1; req1_c = 8'd1; req1_x = 8'd1;
    for (int k = 0; k < 4; k++) begin
      bit ok;
      if (k % 2 == 0) begin req0_valid = 1'b1; req1_valid = 1'b1; end
      ok = 0;
      g  = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (req0_ready || req1_ready) begin ok = 1; g = req1_ready; break; end
      end
      chk("cont_accept_timeout", ok, 1);
      chk("cont_order", g, exp_order[k]);
      sync();
      acc = cyc;
      if (g == 1) req1_valid = 1'b0; else req0_valid = 1'b0;
      get_resp(acc, d, id, lat);
      chk("cont_id", id, exp_order[k]);
      chk("cont_data", d, exp_order[k] == 0 ? 69 : 3);
    end

    // Backpressure
    resp_ready = 1'b0;
    send(0, 2, 3, 4, 5, acc);
    get_resp(acc, d, id, lat);
    chk("bp_data", d, 69);
    req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_valid_held", resp_valid, 1);
      chk("bp_data_held", resp_data, 69);
      chk("bp_id_held", resp_id, 0);
      chk("bp_ready0", req0_ready, 0);
      chk("bp_ready1", req1_ready, 0);
      sync();
    end
    resp_ready = 1'b1;
    sync();
    req1_valid = 1'b0;
    @(negedge clk);
    chk("bp_release_busy", busy, 0);
    chk("bp_release_valid", resp_valid, 0);
    sync();

    // Operand change after accept
    send(0, 2, 3, 4, 5, acc);
    req0_x = 8'd9;
    get_resp(acc, d, id, lat);
    chk("opchg_data", d, 69);

    // Reset during MUL_XX
    send(0, 1, 2, 3, 4, acc);
    sync();
    sync();
    resetn = 1'b0;
    sync();
    resetn = 1'b1;
    @(negedge clk);
    chk("midrst_valid", resp_valid, 0);
    chk("midrst_busy", busy, 0);
    base = n_dut_resp;
    repeat (10) sync();
    chk("midrst_no_resp", n_dut_resp - base, 0);
    send(0, 1, 1, 1, 1, acc);
    get_resp(acc, d, id, lat);
    chk("fresh_data", d, 3);
    chk("fresh_id", id, 0);

    repeat (2) sync();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/poly_eval_arbiter.md
Name: poly_eval_arbiter

Overview:
- Shared evaluator for y = A*x^2 + B*x + C, all arithmetic modulo 2^W.
- Two requesters share it; each presents all four operands at once over a valid/ready handshake.
- The block arbitrates round-robin between the requesters and sequences one shared add/multiply ALU through a fixed five-step micro-program.
- It returns the result, tagged with the requester ID, over a valid/ready response port; it sits between board-level input logic and the display/LED result path.

Parameters:
- W, 8, operand and result width in bits.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- resetn  in  1  synchronous, active-low reset.
- req0_valid  in  1  requester 0 has an operand set.
- req0_ready  out  1  requester 0 operand set accepted this cycle.
- req0_a, req0_b, req0_c, req0_x  in  W each  requester 0 operands.
- req1_valid  in  1  requester 1 has an operand set.
- req1_ready  out  1  requester 1 operand set accepted this cycle.
- req1_a, req1_b, req1_c, req1_x  in  W each  requester 1 operands.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes the result.
- resp_data  out  W  A*x*x + B*x + C, truncated to W bits.
- resp_id  out  1  requester that issued the result.
- busy  out  1  high in every state except IDLE.

Behaviour:
- States: IDLE, MUL_BX, ADD_C, MUL_XX, MUL_A, ADD_R, DONE.
- Reset values: state IDLE; resp_valid 0; resp_data 0; resp_id 0; busy 0; RR pointer 0 (requester 0 preferred); all internal operand and temp registers 0.
- req_ready rules:
  - req0_ready and req1_ready are combinational and asserted only in IDLE.
  - Never both high.
  - Only one requester valid: that one is granted.
  - Both valid: grant the one the pointer prefers.
- Accept: a handshake edge in IDLE loads a, b, c, x and id from the granted port, toggles the pointer to prefer the other requester, and moves to MUL_BX.
- Micro-program, one ALU operation per cycle; every product and sum is truncated to W bits at each step:
  - MUL_BX: t <= b*x
  - ADD_C: t <= t + c
  - MUL_XX: u <= x*x
  - MUL_A: u <= u*a
  - ADD_R: resp_data <= u + t; resp_id <= id; resp_valid <= 1; go to DONE.
- Latency: resp_valid rises on the 5th rising edge after the accepting edge.
- DONE:
  - resp_data and resp_id are held stable while resp_valid=1 and resp_ready=0.
  - On resp_valid & resp_ready, resp_valid <= 0 and the state returns to IDLE.
  - A new accept is possible no earlier than the following cycle; minimum spacing between accepts is 7 cycles.
- Requester operands are sampled only at the accepting edge; later changes on the inputs do not affect an in-flight operation.
- req_valid deasserting in IDLE before a handshake is legal; no state change.
- resp_ready asserted outside DONE is ignored.
- Reset asserted in any state, mid-operation included: return to the reset values on that edge. The in-flight result is discarded and never presented.

Decomposition:
- Shared package:
  - state localparams (3-bit encoding);
  - ALU op codes (OP_ADD=0, OP_MUL=1);
  - operand-select codes (SEL_A, SEL_B, SEL_C, SEL_X, SEL_T, SEL_U).
- Sub-module poly_alu_dp:
  - holds the a/b/c/x/t/u registers, two operand-select muxes and the W-bit add/mul ALU;
  - driven by load enables, selects and op from the controller FSM in poly_eval_arbiter.
- The arbitration pointer and the FSM stay in the top module.

Test Plan:
- Basic: req0 a=2, b=3, c=4, x=5 -> resp_data=69 (0x45), resp_id=0, resp_valid high exactly 5 edges after accept; busy high from accept until the response handshake.
- Wrap: req1 a=1, b=0, c=0, x=16 -> resp_data=0, resp_id=1. Then req1 a=16, b=1, c=0, x=4 -> resp_data=4.
- Contention: req0 and req1 both valid from reset, resp_ready=1:
  - req0 served first, then req1;
  - both re-presented -> req0 then req1 again;
  - never both readies high in any cycle.
- Backpressure: after a result with value 69 (0x45), hold resp_ready=0 for 4 cycles -> resp_data/resp_id stable, resp_valid held, both req_ready 0; release -> back to IDLE in 1 cycle.
- Operand change: alter req0_x from 5 to 9 on the cycle after the accept -> result still 69.
- Reset mid-op: assert resetn=0 for one cycle during MUL_XX -> next cycle resp_valid=0 and busy=0, and no response for that operation. A fresh request a=1, b=1, c=1, x=1 then returns 3.
